// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: FSM state encoding and ROM entry markers.
package tone_sequencer_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // A ROM entry with this length terminates the sequence.
    localparam int unsigned END_LEN  = 0;
    // A ROM entry with this divisor is a silent note.
    localparam int unsigned REST_DIV = 0;

    typedef enum logic [2:0] {
        StIdle  = S_IDLE,
        StFetch = S_FETCH,
        StLoad  = S_LOAD,
        StPlay  = S_PLAY,
        StGap   = S_GAP,
        StDone  = S_DONE
    } state_e;

endpackage

// File: rtl/tone_div.sv
// Programmable 50% square-wave divider with a registered output.
module tone_div
    import tone_sequencer_pkg::*;
#(
    parameter int unsigned DIV_W = 28
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] divisor,
    output logic             tone_out
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             silent;

    // Divisors 0 (rest) and 1 cannot produce a meaningful tone.
    assign silent = (divisor == DIV_W'(REST_DIV)) || (divisor == DIV_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (clr) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (en) begin
            if (silent) begin
                cnt_d = '0;
                out_d = 1'b0;
            end else begin
                out_d = (cnt_q < (divisor >> 1));
                cnt_d = (cnt_q >= divisor - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign tone_out = out_q;

endmodule

// File: rtl/tone_sequencer.sv
// Note-sequence player: walks a {divisor, length} ROM and drives a square-wave tone.
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 500000,
    parameter int unsigned GAP_TICKS = 2,
    parameter int unsigned DIV_W     = 28,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DIV_W-1:0]  rom_divisor,
    input  logic [LEN_W-1:0]  rom_len,
    output logic              busy,
    output logic              done,
    output logic              tone_out
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [LEN_W-1:0] GAP_LAST  = LEN_W'(GAP_TICKS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [LEN_W-1:0]  tick_num_q, tick_num_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick_last;
    logic              tone_clr;
    logic              tone_en;

    assign tick_last = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        div_d      = div_q;
        len_d      = len_q;
        tick_cnt_d = tick_cnt_q;
        tick_num_d = tick_num_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    addr_d  = '0;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                div_d      = rom_divisor;
                len_d      = rom_len;
                tick_cnt_d = '0;
                tick_num_d = '0;
                if (rom_len != LEN_W'(END_LEN)) begin
                    state_d = StPlay;
                end else if (loop_en && (addr_q != '0)) begin
                    addr_d  = '0;
                    state_d = StFetch;
                end else begin
                    state_d = StDone;
                end
            end
            StPlay: begin
                if (tick_last) begin
                    tick_cnt_d = '0;
                    if (tick_num_q == len_q - LEN_W'(1)) begin
                        tick_num_d = '0;
                        state_d    = StGap;
                    end else begin
                        tick_num_d = tick_num_q + LEN_W'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            StGap: begin
                if (tick_last) begin
                    tick_cnt_d = '0;
                    if (tick_num_q == GAP_LAST) begin
                        tick_num_d = '0;
                        addr_d     = addr_q + ADDR_W'(1);
                        state_d    = StFetch;
                    end else begin
                        tick_num_d = tick_num_q + LEN_W'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort overrides every transition, including a simultaneous start.
        if (stop) begin
            state_d = StIdle;
        end
    end

    assign busy_d = (state_d != StIdle);
    assign done_d = (state_d == StDone);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            div_q      <= '0;
            len_q      <= '0;
            tick_cnt_q <= '0;
            tick_num_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            div_q      <= div_d;
            len_q      <= len_d;
            tick_cnt_q <= tick_cnt_d;
            tick_num_q <= tick_num_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Clearing on any cycle that does not stay in PLAY keeps the registered
    // tone low outside PLAY and restarts the phase at every note.
    assign tone_clr = (state_q != StPlay) || (state_d != StPlay);
    assign tone_en  = (state_q == StPlay);

    tone_div #(
        .DIV_W (DIV_W)
    ) u_tone_div (
        .clock_in (clock_in),
        .reset    (reset),
        .clr      (tone_clr),
        .en       (tone_en),
        .divisor  (div_q),
        .tone_out (tone_out)
    );

    assign rom_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a 1-cycle-latency note ROM model.
module tb_tone_sequencer;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned GAP_TICKS = 1;
    localparam int unsigned DIV_W     = 28;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DEPTH     = 2 ** ADDR_W;

    logic              clock_in = 1'b0;
    logic              reset    = 1'b1;
    logic              start    = 1'b0;
    logic              stop     = 1'b0;
    logic              loop_en  = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DIV_W-1:0]  rom_divisor;
    logic [LEN_W-1:0]  rom_len;
    logic              busy;
    logic              done;
    logic              tone_out;

    logic [DIV_W-1:0]  mem_div [DEPTH];
    logic [LEN_W-1:0]  mem_len [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) begin
        rom_divisor <= mem_div[rom_addr];
        rom_len     <= mem_len[rom_addr];
    end

    tone_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .GAP_TICKS (GAP_TICKS),
        .DIV_W     (DIV_W),
        .LEN_W     (LEN_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .rom_addr    (rom_addr),
        .rom_divisor (rom_divisor),
        .rom_len     (rom_len),
        .busy        (busy),
        .done        (done),
        .tone_out    (tone_out)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [ADDR_W-1:0] obs,
                        input logic [ADDR_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    // pat holds the expected tone, first cycle in bit n-1.
    task automatic tone_seq(input string tag, input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            chk1(tag, tone_out, pat[n-1-i]);
            cyc(1);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_div[i] = '0;
            mem_len[i] = '0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        clear_rom();

        // Reset state
        reset = 1'b1;
        cyc(2);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_tone", tone_out, 1'b0);
        chka("rst_addr", rom_addr, '0);
        reset = 1'b0;
        cyc(1);

        // Test 1: one note div 4 len 2, then end marker
        clear_rom();
        mem_div[0] = DIV_W'(4);
        mem_len[0] = LEN_W'(2);
        pulse_start();
        chk1("t1_busy_fetch", busy, 1'b1);
        chka("t1_addr_fetch", rom_addr, '0);
        chk1("t1_tone_fetch", tone_out, 1'b0);
        cyc(2);
        tone_seq("t1_play", 32'b01100110, 8);
        tone_seq("t1_gap", 32'b0, 4);
        chka("t1_addr_next", rom_addr, ADDR_W'(1));
        chk1("t1_busy_next", busy, 1'b1);
        cyc(1);
        chk1("t1_done_load", done, 1'b0);
        cyc(1);
        chk1("t1_done", done, 1'b1);
        chk1("t1_busy_done", busy, 1'b1);
        cyc(1);
        chk1("t1_done_fall", done, 1'b0);
        chk1("t1_busy_fall", busy, 1'b0);

        // Test 2: rest, then div 6 note
        clear_rom();
        mem_div[0] = DIV_W'(0);
        mem_len[0] = LEN_W'(1);
        mem_div[1] = DIV_W'(6);
        mem_len[1] = LEN_W'(2);
        pulse_start();
        cyc(2);
        tone_seq("t2_rest", 32'b0, 4);
        tone_seq("t2_gap", 32'b0, 4);
        chka("t2_addr1", rom_addr, ADDR_W'(1));
        cyc(2);
        tone_seq("t2_play", 32'b01110001, 8);
        cyc(6);
        chk1("t2_done", done, 1'b1);
        cyc(1);
        chk1("t2_busy_fall", busy, 1'b0);

        // Test 3: looping, then stop mid-PLAY
        clear_rom();
        mem_div[0] = DIV_W'(4);
        mem_len[0] = LEN_W'(2);
        loop_en = 1'b1;
        pulse_start();
        cyc(14);
        chka("t3_addr1", rom_addr, ADDR_W'(1));
        cyc(2);
        chka("t3_addr_loop", rom_addr, '0);
        chk1("t3_no_done", done, 1'b0);
        chk1("t3_busy_loop", busy, 1'b1);
        cyc(2);
        tone_seq("t3_replay", 32'b0, 1);
        chk1("t3_tone_hi", tone_out, 1'b1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk1("t3_stop_tone", tone_out, 1'b0);
        chk1("t3_stop_busy", busy, 1'b0);
        chk1("t3_stop_done", done, 1'b0);
        cyc(1);
        chk1("t3_stop_done2", done, 1'b0);
        chk1("t3_stop_busy2", busy, 1'b0);
        loop_en = 1'b0;

        // Test 4: start+stop together, then start during PLAY
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        chk1("t4_ss_busy", busy, 1'b0);
        cyc(1);
        chk1("t4_ss_busy2", busy, 1'b0);
        chk1("t4_ss_tone", tone_out, 1'b0);
        pulse_start();
        cyc(4);
        chk1("t4_tone_hi", tone_out, 1'b1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk1("t4_busy", busy, 1'b1);
        chka("t4_addr", rom_addr, '0);
        cyc(9);
        chka("t4_addr1", rom_addr, ADDR_W'(1));
        cyc(2);
        chk1("t4_done", done, 1'b1);
        cyc(1);
        chk1("t4_busy_fall", busy, 1'b0);

        // Test 5: end marker at address 0, even with loop_en
        clear_rom();
        loop_en = 1'b1;
        pulse_start();
        chk1("t5_busy", busy, 1'b1);
        chk1("t5_tone1", tone_out, 1'b0);
        cyc(1);
        chk1("t5_done_early", done, 1'b0);
        chk1("t5_tone2", tone_out, 1'b0);
        cyc(1);
        chk1("t5_done", done, 1'b1);
        chk1("t5_tone3", tone_out, 1'b0);
        cyc(1);
        chk1("t5_done_fall", done, 1'b0);
        chk1("t5_busy_fall", busy, 1'b0);
        loop_en = 1'b0;

        // Test 6: reset mid-PLAY of the second note, then replay
        mem_div[0] = DIV_W'(0);
        mem_len[0] = LEN_W'(1);
        mem_div[1] = DIV_W'(6);
        mem_len[1] = LEN_W'(2);
        pulse_start();
        cyc(14);
        chk1("t6_tone_hi", tone_out, 1'b1);
        chka("t6_addr1", rom_addr, ADDR_W'(1));
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk1("t6_rst_tone", tone_out, 1'b0);
        chk1("t6_rst_busy", busy, 1'b0);
        chk1("t6_rst_done", done, 1'b0);
        chka("t6_rst_addr", rom_addr, '0);
        cyc(1);
        chk1("t6_idle_busy", busy, 1'b0);
        pulse_start();
        chka("t6_re_addr", rom_addr, '0);
        chk1("t6_re_busy", busy, 1'b1);
        cyc(2);
        tone_seq("t6_re_rest", 32'b0, 8);
        chka("t6_re_addr1", rom_addr, ADDR_W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
